// File: rtl/sprite_plotter.sv
// sprite_plotter: sweeps an SPR_W x SPR_H block in raster order and emits
// one registered VGA pixel write per clock. Pixels that fall outside the
// visible screen are swept but not plotted. An erase request paints the
// block in BG_COLOUR. A request is accepted through a start/busy/done
// handshake.
module sprite_plotter #(
  parameter int          SPR_W     = 4,
  parameter int          SPR_H     = 4,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter int          SCREEN_W  = 160,
  parameter int          SCREEN_H  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] col_in,
  input  logic       erase,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot
);

  // DRAW presents one pixel per edge. FLUSH is the last busy cycle and
  // produces the done pulse on its way back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Offset counters are 4 bits wide, which covers sprite sizes up to 16.
  localparam logic [3:0] CX_LAST  = 4'(SPR_W - 1);
  localparam logic [3:0] CY_LAST  = 4'(SPR_H - 1);
  localparam logic [8:0] X_LIMIT  = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIMIT  = 8'(SCREEN_H);

  state_t      state_reg, state_next;
  logic [3:0]  cx_reg, cx_next;
  logic [3:0]  cy_reg, cy_next;
  logic [7:0]  ox_reg, ox_next;
  logic [6:0]  oy_reg, oy_next;
  logic [2:0]  col_reg, col_next;

  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        plot_reg, plot_next;
  logic [7:0]  vga_x_reg, vga_x_next;
  logic [6:0]  vga_y_reg, vga_y_next;
  logic [2:0]  vga_colour_reg, vga_colour_next;

  // The sums are one bit wider than the screen coordinates. This lets an
  // origin near the right or bottom edge clip cleanly instead of wrapping
  // back onto the screen.
  logic [8:0]  sum_x;
  logic [7:0]  sum_y;
  logic        on_screen;

  assign sum_x     = {1'b0, ox_reg} + {5'b0, cx_reg};
  assign sum_y     = {1'b0, oy_reg} + {4'b0, cy_reg};
  assign on_screen = (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_next      = state_reg;
    cx_next         = cx_reg;
    cy_next         = cy_reg;
    ox_next         = ox_reg;
    oy_next         = oy_reg;
    col_next        = col_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    plot_next       = 1'b0;
    vga_x_next      = vga_x_reg;
    vga_y_next      = vga_y_reg;
    vga_colour_next = vga_colour_reg;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          // The request fields are captured only on this accepting edge.
          ox_next    = x_in;
          oy_next    = y_in;
          col_next   = erase ? BG_COLOUR : col_in;
          cx_next    = 4'd0;
          cy_next    = 4'd0;
          busy_next  = 1'b1;
          state_next = DRAW;
        end
      end

      DRAW: begin
        busy_next       = 1'b1;
        vga_x_next      = sum_x[7:0];
        vga_y_next      = sum_y[6:0];
        vga_colour_next = col_reg;
        plot_next       = on_screen;
        if (cx_reg == CX_LAST) begin
          cx_next = 4'd0;
          if (cy_reg == CY_LAST) begin
            cy_next    = 4'd0;
            state_next = FLUSH;
          end else begin
            cy_next = cy_reg + 4'd1;
          end
        end else begin
          cx_next = cx_reg + 4'd1;
        end
      end

      FLUSH: begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and output registers. Reset aborts any sweep at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cx_reg         <= 4'd0;
      cy_reg         <= 4'd0;
      ox_reg         <= 8'd0;
      oy_reg         <= 7'd0;
      col_reg        <= 3'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      plot_reg       <= 1'b0;
      vga_x_reg      <= 8'd0;
      vga_y_reg      <= 7'd0;
      vga_colour_reg <= 3'd0;
    end else begin
      state_reg      <= state_next;
      cx_reg         <= cx_next;
      cy_reg         <= cy_next;
      ox_reg         <= ox_next;
      oy_reg         <= oy_next;
      col_reg        <= col_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      plot_reg       <= plot_next;
      vga_x_reg      <= vga_x_next;
      vga_y_reg      <= vga_y_next;
      vga_colour_reg <= vga_colour_next;
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign plot       = plot_reg;
  assign vga_x      = vga_x_reg;
  assign vga_y      = vga_y_reg;
  assign vga_colour = vga_colour_reg;

endmodule
